// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues held load/store/LL/SC requests to the
// data cache, captures load data and owns the LL/SC link register.
module mem_access_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dREN_EX_MEM,
    input  logic        dWEN_EX_MEM,
    input  logic        ll_EX_MEM,
    input  logic        sc_EX_MEM,
    input  logic [31:0] result_EX_MEM,
    input  logic [31:0] store_EX_MEM,
    input  logic        halt_EX_MEM,
    input  logic        enable_MEM_WB,
    input  logic        dhit,
    input  logic [31:0] dload,
    input  logic        snoop_inv,
    input  logic [31:0] snoop_addr,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    output logic [31:0] dmemload,
    output logic        stall_MEM
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_next;
    logic        pend, sc_req, sc_ok, sc_fail;
    logic        issue, fail_sc, complete;
    logic        is_ll, is_sc;
    logic        ll_done, store_hits_link, snoop_hit;
    logic        link_valid;
    logic [29:0] link_addr;
    logic        snoop_unused;

    function automatic logic word_match(input logic [29:0] a, input logic [29:0] b);
        return a == b;
    endfunction

    assign snoop_unused = ^snoop_addr[1:0];

    assign pend    = (dREN_EX_MEM | dWEN_EX_MEM) & ~halt_EX_MEM;
    assign sc_req  = sc_EX_MEM & dWEN_EX_MEM;
    assign sc_ok   = link_valid & word_match(link_addr, result_EX_MEM[31:2]);
    assign sc_fail = sc_req & ~sc_ok;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        fail_sc    = 1'b0;
        complete   = 1'b0;
        stall_MEM  = 1'b0;
        case (state)
            IDLE: begin
                stall_MEM = pend;
                if (pend) begin
                    if (sc_fail) begin
                        fail_sc    = 1'b1;
                        state_next = DONE;
                    end else begin
                        issue      = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                stall_MEM = 1'b1;
                if (dhit) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (enable_MEM_WB) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (RST) stall_MEM = 1'b0;
    end

    // Cache request registers: held unchanged from issue until dhit
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dREN     <= 1'b0;
            dWEN     <= 1'b0;
            daddr    <= '0;
            dstore   <= '0;
            dmemload <= '0;
            is_ll    <= 1'b0;
            is_sc    <= 1'b0;
        end else begin
            if (issue) begin
                dREN   <= dREN_EX_MEM;
                dWEN   <= dWEN_EX_MEM;
                daddr  <= result_EX_MEM;
                dstore <= store_EX_MEM;
                is_ll  <= ll_EX_MEM & dREN_EX_MEM;
                is_sc  <= sc_req;
            end
            if (complete) begin
                dREN <= 1'b0;
                dWEN <= 1'b0;
                if (dREN)       dmemload <= dload;
                else if (is_sc) dmemload <= 32'd1;
            end
            if (fail_sc) dmemload <= '0;
        end
    end

    assign ll_done         = complete & is_ll;
    assign store_hits_link = complete & dWEN & ~is_sc & word_match(link_addr, daddr[31:2]);
    // A snoop must also kill a link being created in the same cycle
    assign snoop_hit       = snoop_inv & (word_match(link_addr, snoop_addr[31:2]) |
                                          (ll_done & word_match(daddr[31:2], snoop_addr[31:2])));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            if (ll_done) begin
                link_valid <= 1'b1;
                link_addr  <= daddr[31:2];
            end
            if ((issue | fail_sc) & sc_req) link_valid <= 1'b0;
            if (store_hits_link)            link_valid <= 1'b0;
            if (snoop_hit)                  link_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl: loads, stores, LL/SC,
// snoop invalidation, asynchronous reset and halt behaviour.
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dREN_EX_MEM, dWEN_EX_MEM, ll_EX_MEM, sc_EX_MEM;
    logic [31:0] result_EX_MEM, store_EX_MEM;
    logic        halt_EX_MEM, enable_MEM_WB, dhit;
    logic [31:0] dload;
    logic        snoop_inv;
    logic [31:0] snoop_addr;
    logic        dREN, dWEN, stall_MEM;
    logic [31:0] daddr, dstore, dmemload;

    int compared   = 0;
    int mismatched = 0;

    mem_access_ctrl dut (
        .CLK(CLK), .RST(RST),
        .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM),
        .ll_EX_MEM(ll_EX_MEM), .sc_EX_MEM(sc_EX_MEM),
        .result_EX_MEM(result_EX_MEM), .store_EX_MEM(store_EX_MEM),
        .halt_EX_MEM(halt_EX_MEM), .enable_MEM_WB(enable_MEM_WB),
        .dhit(dhit), .dload(dload),
        .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dmemload(dmemload), .stall_MEM(stall_MEM)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_ex();
        dREN_EX_MEM   = 1'b0;
        dWEN_EX_MEM   = 1'b0;
        ll_EX_MEM     = 1'b0;
        sc_EX_MEM     = 1'b0;
        halt_EX_MEM   = 1'b0;
        enable_MEM_WB = 1'b0;
        result_EX_MEM = '0;
        store_EX_MEM  = '0;
    endtask

    // Leave DONE: pipeline advances and EX/MEM moves on to a non-memory op
    task automatic retire();
        enable_MEM_WB = 1'b1;
        tick();
        clear_ex();
    endtask

    // LL with dhit in the first REQ cycle, then retired
    task automatic do_ll(input logic [31:0] addr, input logic [31:0] data);
        dREN_EX_MEM = 1'b1; ll_EX_MEM = 1'b1; result_EX_MEM = addr;
        tick();
        dhit = 1'b1; dload = data;
        tick();
        dhit = 1'b0;
        retire();
    endtask

    initial begin
        clear_ex();
        dhit = 1'b0; dload = '0; snoop_inv = 1'b0; snoop_addr = '0;
        RST = 1'b1;
        dREN_EX_MEM = 1'b1; result_EX_MEM = 32'h100;
        #3;
        check("rst_stall_forced", stall_MEM, 0);
        check("rst_dREN", dREN, 0);
        check("rst_daddr", daddr, 0);
        check("rst_dmemload", dmemload, 0);
        clear_ex();
        tick();
        RST = 1'b0;
        tick();

        // LW 0x100, dhit on third REQ cycle
        dREN_EX_MEM = 1'b1; result_EX_MEM = 32'h100;
        #1;
        check("lw_idle_stall", stall_MEM, 1);
        check("lw_idle_no_dREN", dREN, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lw_req_dREN", dREN, 1);
            check("lw_req_daddr", daddr, 32'h100);
            check("lw_req_stall", stall_MEM, 1);
            if (i == 2) begin dhit = 1'b1; dload = 32'hDEADBEEF; end
            tick();
        end
        dhit = 1'b0; dload = '0;
        check("lw_done_dREN", dREN, 0);
        check("lw_done_stall", stall_MEM, 0);
        check("lw_done_data", dmemload, 32'hDEADBEEF);
        tick();
        check("lw_done_hold_stall", stall_MEM, 0);
        check("lw_done_hold_dREN", dREN, 0);
        check("lw_done_hold_data", dmemload, 32'hDEADBEEF);
        retire();
        #1;
        check("idle_nop_stall", stall_MEM, 0);

        // SW 0x12345678 to 0x200, dhit after one cycle
        dWEN_EX_MEM = 1'b1; result_EX_MEM = 32'h200; store_EX_MEM = 32'h12345678;
        #1;
        check("sw_idle_stall", stall_MEM, 1);
        tick();
        check("sw_req_dWEN", dWEN, 1);
        check("sw_req_dstore", dstore, 32'h12345678);
        check("sw_req_daddr", daddr, 32'h200);
        check("sw_req_stall", stall_MEM, 1);
        dhit = 1'b1;
        tick();
        dhit = 1'b0;
        check("sw_done_dWEN", dWEN, 0);
        check("sw_done_stall", stall_MEM, 0);
        check("sw_done_data_kept", dmemload, 32'hDEADBEEF);
        retire();

        // LL 0x300 then SC 0x300 succeeds
        do_ll(32'h300, 32'hAAAA5555);
        check("ll_data", dmemload, 32'hAAAA5555);
        dWEN_EX_MEM = 1'b1; sc_EX_MEM = 1'b1; result_EX_MEM = 32'h300; store_EX_MEM = 32'h77;
        tick();
        check("sc_ok_dWEN", dWEN, 1);
        check("sc_ok_stall", stall_MEM, 1);
        dhit = 1'b1;
        tick();
        dhit = 1'b0;
        check("sc_ok_flag", dmemload, 1);
        check("sc_ok_done_dWEN", dWEN, 0);
        retire();

        // Second SC fails: no write, one stall cycle
        dWEN_EX_MEM = 1'b1; sc_EX_MEM = 1'b1; result_EX_MEM = 32'h300;
        #1;
        check("sc2_idle_stall", stall_MEM, 1);
        tick();
        check("sc2_no_dWEN", dWEN, 0);
        check("sc2_done_stall", stall_MEM, 0);
        check("sc2_flag", dmemload, 0);
        retire();

        // Snoop to a different word keeps the link
        do_ll(32'h300, 32'h11112222);
        snoop_inv = 1'b1; snoop_addr = 32'h304;
        tick();
        snoop_inv = 1'b0;
        dWEN_EX_MEM = 1'b1; sc_EX_MEM = 1'b1; result_EX_MEM = 32'h300;
        tick();
        check("snoop_other_sc_dWEN", dWEN, 1);
        dhit = 1'b1;
        tick();
        dhit = 1'b0;
        check("snoop_other_sc_flag", dmemload, 1);
        retire();

        // Snoop to same word (byte offset differs) kills the link
        do_ll(32'h300, 32'h33334444);
        snoop_inv = 1'b1; snoop_addr = 32'h302;
        tick();
        snoop_inv = 1'b0;
        dWEN_EX_MEM = 1'b1; sc_EX_MEM = 1'b1; result_EX_MEM = 32'h300;
        tick();
        check("snoop_sc_no_dWEN", dWEN, 0);
        check("snoop_sc_flag", dmemload, 0);
        retire();

        // Plain store to the linked word kills the link
        do_ll(32'h800, 32'h55556666);
        dWEN_EX_MEM = 1'b1; result_EX_MEM = 32'h800; store_EX_MEM = 32'h9;
        tick();
        dhit = 1'b1;
        tick();
        dhit = 1'b0;
        retire();
        dWEN_EX_MEM = 1'b1; sc_EX_MEM = 1'b1; result_EX_MEM = 32'h800;
        tick();
        check("st_kill_sc_no_dWEN", dWEN, 0);
        check("st_kill_sc_flag", dmemload, 0);
        retire();

        // Asynchronous reset in the middle of REQ
        do_ll(32'h400, 32'hCAFEF00D);
        dREN_EX_MEM = 1'b1; result_EX_MEM = 32'h500;
        tick();
        check("pre_rst_dREN", dREN, 1);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_dREN", dREN, 0);
        check("async_rst_daddr", daddr, 0);
        check("async_rst_dmemload", dmemload, 0);
        check("async_rst_stall", stall_MEM, 0);
        #3;
        RST = 1'b0;
        clear_ex();
        tick();
        dWEN_EX_MEM = 1'b1; sc_EX_MEM = 1'b1; result_EX_MEM = 32'h400;
        #1;
        check("post_rst_idle_stall", stall_MEM, 1);
        tick();
        check("post_rst_sc_no_dWEN", dWEN, 0);
        check("post_rst_sc_stall", stall_MEM, 0);
        retire();

        // Halt in IDLE blocks the new request
        dREN_EX_MEM = 1'b1; halt_EX_MEM = 1'b1; result_EX_MEM = 32'h600;
        #1;
        check("halt_idle_stall", stall_MEM, 0);
        tick();
        check("halt_idle_dREN", dREN, 0);
        check("halt_idle_stall2", stall_MEM, 0);
        clear_ex();
        tick();

        // Halt rising during REQ: request held until dhit
        dREN_EX_MEM = 1'b1; result_EX_MEM = 32'h700;
        tick();
        halt_EX_MEM = 1'b1;
        #1;
        check("halt_req_dREN", dREN, 1);
        check("halt_req_stall", stall_MEM, 1);
        tick();
        check("halt_req_held_dREN", dREN, 1);
        check("halt_req_held_daddr", daddr, 32'h700);
        dhit = 1'b1; dload = 32'h13579BDF;
        tick();
        dhit = 1'b0;
        check("halt_req_done_dREN", dREN, 0);
        check("halt_req_done_data", dmemload, 32'h13579BDF);
        check("halt_req_done_stall", stall_MEM, 0);
        retire();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
